// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// Holds the loader FSM encoding, the receiver state encoding and the frame sync value.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_H  = 4'd1,
        ST_LEN_L  = 4'd2,
        ST_ADDR_H = 4'd3,
        ST_ADDR_L = 4'd4,
        ST_DATA   = 4'd5,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM   = 4'd6,
`endif
        ST_DONE   = 4'd7,
        ST_ERR    = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, single-cycle
// byte_valid_o / framing_err_o pulses with the byte held on byte_o.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       framing_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    assign rx_s          = sync_q[1];
    assign byte_o        = shift_q;
    assign byte_valid_o  = valid_q;
    assign framing_err_o = ferr_q;

    // Input synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: start qualified at half a bit, data and stop sampled a full bit apart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (!rx_s) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: parses SYNC/LEN/ADDR/data frames and writes RAM port A.
// Define PROG_LOADER_CHECKSUM_EN to expect and verify a trailing checksum byte.
module prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CLKS);

    logic [7:0]  rx_byte_s;
    logic        rx_valid_s;
    logic        rx_ferr_s;
    logic        fail_s;

    state_e      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  data_q, data_d;
    logic        wren_q, wren_d;
    logic        hold_q, hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] tmo_q, tmo_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .rx_i          (uart_rx),
        .byte_o        (rx_byte_s),
        .byte_valid_o  (rx_valid_s),
        .framing_err_o (rx_ferr_s)
    );

    assign ram_address = ptr_q;
    assign ram_data    = data_q;
    assign ram_wren    = wren_q;
    assign cpu_hold    = hold_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;

    // busy is high exactly while a frame is being parsed, so it gates failure detection.
    assign fail_s = busy_q && (rx_ferr_s || (tmo_q >= TMO_LIMIT));

    // Loader state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 16'h0000;
            len_q   <= 16'h0000;
            data_q  <= 8'h00;
            wren_q  <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Frame parser; status outputs change together with the state they belong to.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (!busy_q || rx_valid_s) begin
            tmo_d = 32'd0;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_s && (rx_byte_s == SYNC_BYTE)) begin
                    state_d = ST_LEN_H;
                    busy_d  = 1'b1;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN_H: begin
                if (rx_valid_s) begin
                    len_d[15:8] = rx_byte_s;
                    state_d     = ST_LEN_L;
                end else begin
                    state_d = ST_LEN_H;
                end
            end
            ST_LEN_L: begin
                if (rx_valid_s) begin
                    len_d[7:0] = rx_byte_s;
                    state_d    = ST_ADDR_H;
                end else begin
                    state_d = ST_LEN_L;
                end
            end
            ST_ADDR_H: begin
                if (rx_valid_s) begin
                    ptr_d[15:8] = rx_byte_s;
                    state_d     = ST_ADDR_L;
                end else begin
                    state_d = ST_ADDR_H;
                end
            end
            ST_ADDR_L: begin
                if (rx_valid_s) begin
                    ptr_d[7:0] = rx_byte_s;
                    if (len_q != 16'h0000) begin
                        state_d = ST_DATA;
                    end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        hold_d  = 1'b0;
`endif
                    end
                end else begin
                    state_d = ST_ADDR_L;
                end
            end
            ST_DATA: begin
                // A byte raises the strobe; the strobe cycle advances the pointer.
                if (rx_valid_s) begin
                    data_d = rx_byte_s;
                    wren_d = 1'b1;
                    len_d  = len_q - 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + rx_byte_s;
`endif
                end else if (wren_q) begin
                    ptr_d = ptr_q + 16'd1;
                    if (len_q == 16'h0000) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid_s) begin
                    busy_d = 1'b0;
                    if (rx_byte_s == sum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fail_s) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b1;
            wren_d  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (CLKS_PER_BIT=4, TIMEOUT_CLKS=200); follows
// PROG_LOADER_CHECKSUM_EN to decide whether frames carry a checksum byte.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        rx_line;
    logic [15:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp;
    int n_fail;
    int n_double;
    logic        wren_prev;
    logic [23:0] wr_q[$];
    logic [23:0] exp_q[$];
    logic [7:0]  tx_q[$];

    prog_loader #(
        .CLKS_PER_BIT (4),
        .TIMEOUT_CLKS (200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (rx_line),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: logs every strobe and flags strobes longer than one cycle.
    always @(negedge clk) begin
        if (!rst && ram_wren) begin
            wr_q.push_back({ram_address, ram_data});
            if (wren_prev) n_double++;
        end
        wren_prev = ram_wren;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_line = 1'b0;
        cycles(4);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            cycles(4);
        end
        rx_line = stop_bit;
        cycles(4);
        rx_line = 1'b1;
        cycles(4);
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        cycles(20);
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_q.size()) chk({tag, "_write"}, {8'h00, wr_q[i]}, {8'h00, exp_q[i]});
        end
        wr_q.delete();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        n_double = 0;
        wren_prev = 1'b0;
        rst = 1'b1;
        rx_line = 1'b1;
        cycles(5);
        chk("reset_outputs", {7'd0, ram_address, ram_data, ram_wren, cpu_hold, busy, done, error}, 32'd0);
        rst = 1'b0;
        cycles(10);

        // Basic 3-byte load at 0x0200.
        tx_q = '{8'hA5};
        send_q();
        chk("sync_busy_hold", {30'd0, busy, cpu_hold}, 32'd3);
        tx_q = '{8'h00, 8'h03, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
`ifdef PROG_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h66);
`endif
        send_q();
        exp_q = '{24'h020011, 24'h020122, 24'h020233};
        chk_writes("frameA");
        chk("frameA_status", {28'd0, busy, cpu_hold, done, error}, 32'h2);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum, then a good frame clears the error.
        tx_q = '{8'hA5, 8'h00, 8'h03, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h67};
        send_q();
        chk_writes("badsum");
        chk("badsum_status", {28'd0, busy, cpu_hold, done, error}, 32'h5);
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h05, 8'h00, 8'h42, 8'h42};
        send_q();
        exp_q = '{24'h050042};
        chk_writes("recover");
        chk("recover_status", {28'd0, busy, cpu_hold, done, error}, 32'h2);
`endif

        // Leading noise ignored; write at 0xFFFF, then pointer wrap to 0x0000.
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h7E};
`ifdef PROG_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h7E);
`endif
        send_q();
        exp_q = '{24'hFFFF7E};
        chk_writes("top_addr");
        chk("top_status", {28'd0, busy, cpu_hold, done, error}, 32'h2);
        chk("ptr_wrapped", {16'd0, ram_address}, 32'h0000);
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h55};
`ifdef PROG_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h55);
`endif
        send_q();
        exp_q = '{24'h000055};
        chk_writes("wrap");
        chk("wrap_status", {28'd0, busy, cpu_hold, done, error}, 32'h2);

        // Inter-byte timeout after the first of two data bytes.
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h00, 8'hAA};
        send_q();
        cycles(250);
        exp_q = '{24'h1000AA};
        chk_writes("timeout");
        chk("timeout_status", {28'd0, busy, cpu_hold, done, error}, 32'h5);

        // Framing error on LEN_L.
        tx_q = '{8'hA5, 8'h00};
        send_q();
        chk("sync_clears_err", {28'd0, busy, cpu_hold, done, error}, 32'hC);
        send_byte(8'h00, 1'b0);
        cycles(60);
        exp_q.delete();
        chk_writes("framing");
        chk("framing_status", {28'd0, busy, cpu_hold, done, error}, 32'h5);

        // Reset after the 2nd of 4 data bytes.
        tx_q = '{8'hA5, 8'h00, 8'h04, 8'h30, 8'h00, 8'hD1, 8'hD2};
        send_q();
        rst = 1'b1;
        cycles(3);
        chk("midreset_outputs", {7'd0, ram_address, ram_data, ram_wren, cpu_hold, busy, done, error}, 32'd0);
        rst = 1'b0;
        tx_q = '{8'hD3, 8'hD4};
        send_q();
        cycles(100);
        exp_q = '{24'h3000D1, 24'h3001D2};
        chk_writes("midreset");
        chk("after_reset_idle", {28'd0, busy, cpu_hold, done, error}, 32'h0);
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h40, 8'h00, 8'hE7};
`ifdef PROG_LOADER_CHECKSUM_EN
        tx_q.push_back(8'hE7);
`endif
        send_q();
        exp_q = '{24'h4000E7};
        chk_writes("post_reset");
        chk("post_reset_status", {28'd0, busy, cpu_hold, done, error}, 32'h2);

        chk("single_cycle_strobe", 32'(n_double), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
